filter_seq: RTL
===============

# filter_seq

Sequencer for the 8-tap median `filter` datapath. It accepts a byte stream over a valid/ready handshake and writes each sample into the filter's window register bank as a circular buffer. It waits out the median latency, then returns one result per sample (median, sample-minus-median, or bypass) on a valid/ready output. It sits between the sample source and the downstream consumer, and drives the filter's write and select ports.

## Interface
- `WIN`, 8: window depth; must match the filter's register bank (pointer width 3).
- `MED_LAT`, 1: cycles from the filter write cycle to a valid median at `f_dout`; legal range 1..15.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `clear` in 1: synchronous flush; restarts window fill.
- `mode` in 2: output mode; sampled on sample accept.
- `s_valid` in 1: input sample valid.
- `s_data` in 8: input sample.
- `s_ready` out 1: controller can accept a sample.
- `m_valid` out 1: result valid.
- `m_data` out 8: result.
- `m_ready` in 1: consumer accepts the result.
- `f_data` out 8: to filter `data_in`.
- `f_addr` out 3: to filter `reg_addr`.
- `f_wr` out 1: to filter `wr_enable`.
- `f_sel` out 2: to filter `out_select`.
- `f_dout` in 8: from filter `data_out`.

## Operation
- States: IDLE, WRITE, WAIT, OUT.
- IDLE: `s_ready`=1. On `s_valid&s_ready`, latch the sample into `f_data` and `mode` into the mode register, then go to WRITE.
- Mode 2'b11 is latched as 2'b00. Modes: 00 = median, 01 = sample − median (mod 256, filter arithmetic), 10 = bypass.
- WRITE (one cycle): `f_wr`=1, `f_addr`=`wptr`.
  - `wptr` increments, wrapping 7→0.
  - `fill` increments, saturating at 8.
  - Next state is WAIT, with the wait counter loaded to MED_LAT.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1:
  - If `fill`==8 or mode==10: capture `f_dout` into `m_data` and go to OUT.
  - Otherwise (window still priming, non-bypass mode): discard the result and go to IDLE.
- OUT: `m_valid`=1, and `m_data` stays stable until `m_ready`. On `m_valid&m_ready`, go to IDLE.
- `f_data` and `f_sel` (the latched mode) stay stable from WRITE through OUT. The difference mode depends on this, because the filter output is combinational in `data_in`.
- `clear`, in any state: go to IDLE next cycle, zero `wptr` and `fill`, drop `m_valid`, and discard the pending result.
  - The filter storage is not zeroed. Stale slots are overwritten during refill, and no non-bypass output is produced before 8 fresh samples.
- `clear` together with `s_valid` in IDLE: `clear` wins; the sample is not accepted.

## Timing
- Reset values: `s_ready`=0 while `rst`=0.
  - State IDLE, `m_valid`=0, `m_data`=0, `f_wr`=0, `f_addr`=0, `f_data`=0, `f_sel`=0, `wptr`=0, `fill`=0.
  - `s_ready` rises in the first cycle after `rst` returns to 1.
- Accept at edge T:
  - WRITE occupies cycle T+1.
  - WAIT occupies T+2..T+1+MED_LAT.
  - `m_valid` rises at T+2+MED_LAT.
- Back-to-back throughput: one sample per MED_LAT+3 cycles when `m_ready` is held high. Back-pressure stalls in OUT indefinitely.
- `s_ready` is 0 in WRITE, WAIT and OUT; there is no overlap between samples.
- Reset mid-operation returns to reset values at the next edge, regardless of state.
- All outputs are registered, except `s_ready` and `m_valid`, which decode directly from the state register.

## Structure
- Shared package `filter_pkg`:
  - state enum `filt_state_t`.
  - mode constants `MODE_MEDIAN`=2'b00, `MODE_DIFF`=2'b01, `MODE_BYPASS`=2'b10.
  - `FILT_WIN`=8.
- Single flat module with no sub-module; the parent instantiates `filter` alongside it.

## Test plan
- Reset, then feed 8 samples 10,20,…,80 in mode 00 → no `m_valid` for the first 7; the 8th yields `m_valid` at accept+3 with `m_data` = the filter median of the window.
- Full window, then sample 200 in mode 01 → `f_wr` at `f_addr`=0 (wrap). The result is 200 minus the new median, mod 256, and `f_data` holds 200 throughout OUT.
- Mode 10 straight after reset, sample 0x5A → output 0x5A despite the window not being full.
- Hold `m_ready`=0 for 5 cycles in OUT → `m_data` stable, `s_ready`=0; the handshake releases, and `s_ready`=1 on the next cycle.
- `clear` asserted during WAIT after 8 samples → `m_valid` never rises, `wptr`=`fill`=0, and the next 7 non-bypass samples produce no output.
- `rst`=0 pulsed during OUT → all outputs reach reset values at the next edge; `s_ready`=1 one cycle after release.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and constants for the median filter sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package filter_pkg;

  localparam int FILT_WIN = 8;

  localparam logic [1:0] MODE_MEDIAN = 2'b00;
  localparam logic [1:0] MODE_DIFF   = 2'b01;
  localparam logic [1:0] MODE_BYPASS = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } filt_state_t;

  // The unused encoding 2'b11 falls back to plain median.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_MEDIAN : m;
  endfunction

endpackage

// File: rtl/filter_seq.sv
// Sequencer for the 8-tap median filter: writes samples round-robin into the window, returns one result per sample.
// Latency: accept at edge T -> WRITE at T+1, WAIT for MED_LAT cycles, m_valid at T+2+MED_LAT; one sample in flight.
// Backpressure: s_ready only in IDLE; the result is held in OUT indefinitely until m_ready.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   clear               synchronous flush, restarts window fill
//   mode                output mode (00 median, 01 sample-median, 10 bypass), sampled on accept
//   s_valid/s_ready/s_data   sample input handshake
//   m_valid/m_ready/m_data   result output handshake
//   f_data/f_addr/f_wr/f_sel drive the filter data_in/reg_addr/wr_enable/out_select
//   f_dout              filter data_out
module filter_seq
  import filter_pkg::*;
#(
  parameter int WIN     = FILT_WIN,
  parameter int MED_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [1:0] mode,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic [7:0] f_data,
  output logic [2:0] f_addr,
  output logic       f_wr,
  output logic [1:0] f_sel,
  input  logic [7:0] f_dout
);

  localparam int PW = $clog2(WIN);
  localparam int FW = $clog2(WIN + 1);

  localparam logic [PW-1:0] PTR_MAX  = PW'(WIN - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(WIN);
  localparam logic [3:0]    LAT_INIT = 4'(MED_LAT);

  filt_state_t   state;
  logic [PW-1:0] wptr;
  logic [FW-1:0] fill;
  logic [3:0]    wait_cnt;

  // Handshake flags decode straight from the state; s_ready is also held
  // low for as long as reset is asserted.
  assign s_ready = rst && (state == ST_IDLE);
  assign m_valid = (state == ST_OUT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      m_data   <= '0;
      f_wr     <= 1'b0;
      f_addr   <= '0;
      f_data   <= '0;
      f_sel    <= MODE_MEDIAN;
      wptr     <= '0;
      fill     <= '0;
      wait_cnt <= '0;
    end else if (clear) begin
      // Filter storage is left as is: stale slots are overwritten during
      // refill and nothing non-bypass comes out before the window is fresh.
      state    <= ST_IDLE;
      f_wr     <= 1'b0;
      wptr     <= '0;
      fill     <= '0;
      wait_cnt <= '0;
    end else begin
      f_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            // f_data/f_sel stay put until the next accept: in difference
            // mode the filter output is combinational in data_in.
            f_data <= s_data;
            f_sel  <= norm_mode(mode);
            f_addr <= wptr;
            f_wr   <= 1'b1;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wptr     <= (wptr == PTR_MAX) ? '0 : wptr + PW'(1);
          fill     <= (fill == FILL_MAX) ? fill : fill + FW'(1);
          wait_cnt <= LAT_INIT;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd1) begin
            // While the window is still priming only bypass has a
            // meaningful result; otherwise drop it silently.
            if (fill == FILL_MAX || f_sel == MODE_BYPASS) begin
              m_data <= f_dout;
              state  <= ST_OUT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_OUT: begin
          if (m_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
